bit_serializer: RTL and testbench
=================================

# bit_serializer

Upstream feeder for the serial pattern-detecting Mealy FSM. Accepts parallel words over a valid/ready handshake and emits them one bit at a time on `x_out`, qualified by a single-cycle `en_out` strobe at a programmable bit period. `x_out`/`en_out` connect directly to the detector's `X`/`en` inputs, so the detector advances exactly once per emitted bit.

## Interface
- `WIDTH`, 8, bits per word (≥2)
- `DIV_W`, 8, width of bit-period divider
- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-high
- `div`  in  DIV_W  bit period minus one; bit period = div+1 cycles
- `lsb_first`  in  1  0 = MSB first, 1 = LSB first
- `in_data`  in  WIDTH  word to serialize
- `in_valid`  in  1  `in_data` valid
- `in_ready`  out  1  block can accept a word this cycle
- `x_out`  out  1  current serial bit (detector `X`)
- `en_out`  out  1  one-cycle strobe; `x_out` is consumed this cycle (detector `en`)
- `busy`  out  1  frame in progress
- `done`  out  1  one-cycle pulse coincident with the last bit's strobe

## Operation
- States: IDLE, SHIFT.
- Registers: shift register (WIDTH), prescaler `cnt` (DIV_W), bit index `idx` (clog2(WIDTH)), latched `div_q` and `lsb_q`.
- Accept: `in_valid && in_ready` at a rising edge loads the shift register from `in_data`, latches `div_q = div` and `lsb_q = lsb_first`, sets `cnt = div`, `idx = 0`, and moves to SHIFT.
- `div`/`lsb_first` changes during a frame have no effect until the next accept.
- `x_out` in SHIFT: MSB of shift register when `lsb_q = 0`, LSB when `lsb_q = 1`. `x_out = 0` in IDLE.
- `en_out = (state == SHIFT) && (cnt == 0)`, combinational from registers.
- In SHIFT with `cnt != 0`: `cnt` decrements; shift register and `idx` hold.
- In SHIFT with `cnt == 0` (strobe cycle):
  - `idx != WIDTH-1`: shift toward the output end (left for MSB-first, right for LSB-first, zero fill), `idx++`, `cnt = div_q`.
  - `idx == WIDTH-1`: last bit. `done = 1`. If `in_valid` is high, accept the new word (reload as above, stay in SHIFT); otherwise go to IDLE.
- `in_ready = (state == IDLE) || (en_out && idx == WIDTH-1)`. This allows gapless back-to-back frames.
- `busy = (state == SHIFT)`.
- `in_data` is ignored when not accepted. Dropping `in_valid` in IDLE is legal.

## Timing
- Reset: state = IDLE; shift register, `cnt`, `idx`, `div_q`, `lsb_q` = 0. Outputs during and after reset: `x_out = 0`, `en_out = 0`, `busy = 0`, `done = 0`, `in_ready = 1` (IDLE).
- Accept at edge T:
  - `busy` and first bit on `x_out` from cycle T+1.
  - First strobe in cycle T+1+div.
  - Subsequent strobes every div+1 cycles.
  - Last strobe and `done` in cycle T+WIDTH·(div+1).
- `div = 0`: strobe every cycle, frame = WIDTH cycles.
- Maximum period: `div = 2^DIV_W−1`, no overflow. `cnt` only decrements from `div_q` to 0.
- `x_out` is stable for the full bit period, including the strobe cycle. It changes only on the edge ending a strobe cycle.
- Back-to-back: a word accepted on the last strobe edge puts its first bit on `x_out` in the next cycle. There is no idle cycle, and `busy` stays high.
- Reset mid-frame: outputs take reset values immediately (async). There is no `done` and no further strobes, and the partial frame is discarded.
- `done` never asserts without `en_out` in the same cycle.

## Test plan
- WIDTH=8, div=0, lsb_first=0, accept 0xA5 at T → `en_out` high cycles T+1..T+8; `x_out` on strobes = 1,0,1,0,0,1,0,1; `done` only at T+8; `in_ready` low T+1..T+7.
- div=2, 0x81 MSB-first → strobes at T+3, T+6, …, T+24 with bits 1,0,0,0,0,0,0,1; each bit held 3 cycles; `done` at T+24.
- lsb_first=1, div=0, 0x01 → bits 1,0,0,0,0,0,0,0; then change `div` to 5 mid-frame → strobe spacing unchanged (1 cycle).
- `in_valid` held with 0xF0 then 0x0F, div=0 → 16 consecutive strobes, bits 1111000000001111; `busy` continuous; `done` pulses at strobes 8 and 16.
- Assert `rst` on the 4th strobe of a 0xFF frame (div=1) → `en_out`, `busy`, `x_out` drop to 0 immediately, no `done`; after release, `in_ready = 1` and a new 0x55 frame serializes correctly.
- Chain into the Mealy detector with a known bit stream → detector `Z` pulses match a golden model driven by the same bits and strobes.

Source files
------------

// File: rtl/bit_serializer.sv
// Parallel-to-serial feeder for the serial pattern detector: shifts out one word
// bit per en_out strobe every div+1 cycles, with gapless back-to-back frames.
module bit_serializer #(
    parameter int WIDTH = 8,
    parameter int DIV_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             lsb_first,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x_out,
    output logic             en_out,
    output logic             busy,
    output logic             done
);
    localparam int                IDX_W    = $clog2(WIDTH);
    localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(WIDTH - 1);
    localparam logic [0:0]        S_IDLE   = 1'b0;
    localparam logic [0:0]        S_SHIFT  = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic             lsb_q, lsb_d;

    logic shift_s;
    logic strobe_s;
    logic last_s;
    logic accept_s;

    assign shift_s  = (state_q == S_SHIFT);
    assign strobe_s = shift_s && (cnt_q == {DIV_W{1'b0}});
    assign last_s   = (idx_q == LAST_IDX);
    assign accept_s = in_valid && in_ready;

    assign en_out   = strobe_s;
    assign done     = strobe_s && last_s;
    assign busy     = shift_s;
    // Ready on the last strobe too, so the next word follows with no idle cycle.
    assign in_ready = !shift_s || done;

    // Serial output: the active end of the shift register, forced low when idle.
    always_comb begin
        x_out = 1'b0;
        if (!shift_s) begin
            x_out = 1'b0;
        end else if (lsb_q) begin
            x_out = shreg_q[0];
        end else begin
            x_out = shreg_q[WIDTH-1];
        end
    end

    // Next-state logic: accept, prescale, shift, or finish the frame.
    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        div_d   = div_q;
        lsb_d   = lsb_q;
        if (accept_s) begin
            state_d = S_SHIFT;
            shreg_d = in_data;
            cnt_d   = div;
            idx_d   = {IDX_W{1'b0}};
            div_d   = div;
            lsb_d   = lsb_first;
        end else if (!shift_s) begin
            state_d = S_IDLE;
        end else if (!strobe_s) begin
            cnt_d = cnt_q - DIV_W'(1);
        end else if (!last_s) begin
            shreg_d = lsb_q ? {1'b0, shreg_q[WIDTH-1:1]} : {shreg_q[WIDTH-2:0], 1'b0};
            idx_d   = idx_q + IDX_W'(1);
            cnt_d   = div_q;
        end else begin
            state_d = S_IDLE;
        end
    end

    // State registers with asynchronous reset to an empty idle frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            shreg_q <= {WIDTH{1'b0}};
            cnt_q   <= {DIV_W{1'b0}};
            idx_q   <= {IDX_W{1'b0}};
            div_q   <= {DIV_W{1'b0}};
            lsb_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            div_q   <= div_d;
            lsb_q   <= lsb_d;
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Self-checking bench for bit_serializer: timeline model built from frame rules,
// directed vector table, random frames, mid-frame reset and a chained detector.
module tb_bit_serializer;
    localparam int W    = 8;
    localparam int DW   = 8;
    localparam int MAXC = 8192;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] div = 8'd0;
    logic          lsb_first = 1'b0;
    logic [W-1:0]  in_data = 8'd0;
    logic          in_valid = 1'b0;
    logic          in_ready, x_out, en_out, busy, done;

    bit_serializer #(.WIDTH(W), .DIV_W(DW)) dut (
        .clk(clk), .rst(rst), .div(div), .lsb_first(lsb_first),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .x_out(x_out), .en_out(en_out), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct {logic [7:0] word; int dv; logic lsb; int gap;} frame_t;
    typedef struct {logic [7:0] word; int dv; logic lsb; int gap; logic [7:0] exp_bits; int exp_len;} vec_t;

    int         n_pass = 0;
    int         n_total = 0;
    frame_t     plan[$];
    logic [4:0] exp_o [MAXC];
    logic       v_a   [MAXC];
    logic [7:0] d_a   [MAXC];
    logic [7:0] div_a [MAXC];
    logic       lsb_a [MAXC];
    int         t_acc[$];
    int         ncyc;
    bit         stream[$];
    bit         obs[$];
    int         obs_cyc[$];

    // Downstream Mealy detector for 1101 (overlapping), clocked by the strobes.
    logic [2:0] det_h;
    int         det_z = 0;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            det_h <= 3'b000;
        end else if (en_out) begin
            det_h <= {det_h[1:0], x_out};
            if ({det_h, x_out} == 4'b1101) det_z <= det_z + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, exp);
    endtask

    function automatic bit frame_bit(input logic [7:0] w, input logic lsb, input int j);
        return lsb ? w[j-1] : w[W-j];
    endfunction

    function automatic logic [4:0] outs();
        return {in_ready, busy, en_out, x_out, done};
    endfunction

    // Expected per-cycle outputs from frame arithmetic: accept at T, strobes at T+j*(div+1).
    task automatic build_plan();
        int pe = 0;
        t_acc.delete();
        stream.delete();
        foreach (plan[i]) pe = pe + plan[i].gap + W * (plan[i].dv + 1);
        ncyc = pe + 4;
        if (ncyc > MAXC) begin
            $display("FAIL plan_size: got %0d expected <= %0d", ncyc, MAXC);
            $fatal(1);
        end
        for (int c = 0; c < ncyc; c++) begin
            exp_o[c] = 5'b10000;
            v_a[c]   = 1'b0;
            d_a[c]   = 8'($urandom);
            div_a[c] = 8'($urandom);
            lsb_a[c] = 1'($urandom);
        end
        pe = 0;
        foreach (plan[i]) begin
            int t = pe + plan[i].gap;
            int p = plan[i].dv + 1;
            int e = t + W * p;
            t_acc.push_back(t);
            v_a[t]   = 1'b1;
            d_a[t]   = plan[i].word;
            div_a[t] = 8'(plan[i].dv);
            lsb_a[t] = plan[i].lsb;
            for (int c = t + 1; c <= e; c++) begin
                int j = (c - t - 1) / p + 1;
                exp_o[c] = {1'b0, 1'b1, ((c - t) % p == 0), frame_bit(plan[i].word, plan[i].lsb, j), (c == e)};
                if (c < e) v_a[c] = 1'($urandom);
            end
            exp_o[e][4] = 1'b1;
            for (int j = 1; j <= W; j++) stream.push_back(frame_bit(plan[i].word, plan[i].lsb, j));
            pe = e;
        end
    endtask

    task automatic run_plan(input string tag);
        obs.delete();
        obs_cyc.delete();
        for (int k = 0; k < ncyc; k++) begin
            @(negedge clk);
            check($sformatf("%s_cyc%0d", tag, k), {27'd0, outs()}, {27'd0, exp_o[k]});
            if (en_out) begin
                obs.push_back(x_out);
                obs_cyc.push_back(k);
            end
            in_valid  = v_a[k];
            in_data   = d_a[k];
            div       = div_a[k];
            lsb_first = lsb_a[k];
        end
        in_valid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vec_t       tbl[8];
        int         z0, gold, s;
        logic [3:0] win;
        logic [2:0] h;
        logic [7:0] pk;

        tbl[0] = '{8'hA5, 0,   1'b0, 1, 8'b10100101, 8};
        tbl[1] = '{8'h81, 2,   1'b0, 2, 8'b10000001, 24};
        tbl[2] = '{8'h01, 0,   1'b1, 1, 8'b10000000, 8};
        tbl[3] = '{8'hF0, 0,   1'b0, 3, 8'b11110000, 8};
        tbl[4] = '{8'h0F, 0,   1'b0, 0, 8'b00001111, 8};
        tbl[5] = '{8'h55, 1,   1'b1, 0, 8'b10101010, 16};
        tbl[6] = '{8'h3C, 3,   1'b1, 2, 8'b00111100, 32};
        tbl[7] = '{8'hC3, 255, 1'b0, 1, 8'b11000011, 2048};

        repeat (2) @(negedge clk);
        check("reset_hold", {27'd0, outs()}, 32'h10);
        rst = 1'b0;
        @(negedge clk);
        check("reset_release", {27'd0, outs()}, 32'h10);

        // Random frames, random gaps (0 = back-to-back), garbage inputs mid-frame.
        plan.delete();
        for (int i = 0; i < 30; i++)
            plan.push_back('{8'($urandom), int'($urandom_range(0, 6)), 1'($urandom), int'($urandom_range(0, 3))});
        build_plan();
        z0 = det_z;
        run_plan("rand");
        check("rand_strobe_count", 32'(obs.size()), 32'(W * 30));
        gold = 0;
        h = 3'b000;
        foreach (stream[i]) begin
            win = {h, stream[i]};
            if (win == 4'b1101) gold++;
            h = {h[1:0], stream[i]};
        end
        check("detector_z_count", 32'(det_z - z0), 32'(gold));

        // Directed vector table.
        plan.delete();
        foreach (tbl[i]) plan.push_back('{tbl[i].word, tbl[i].dv, tbl[i].lsb, tbl[i].gap});
        build_plan();
        run_plan("tbl");
        for (int i = 0; i < 8; i++) begin
            if (obs.size() >= 8 * (i + 1)) begin
                for (int j = 0; j < 8; j++) pk[7-j] = obs[8*i+j];
                check($sformatf("vec%0d_bits", i), 32'(pk), 32'(tbl[i].exp_bits));
                check($sformatf("vec%0d_len", i), 32'(obs_cyc[8*i+7] - t_acc[i]), 32'(tbl[i].exp_len));
            end else begin
                check($sformatf("vec%0d_strobes", i), 32'(obs.size()), 32'(8 * (i + 1)));
            end
        end

        // Reset asserted during the 4th strobe of an 0xFF frame at div=1.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'hFF; div = 8'd1; lsb_first = 1'b0;
        s = 0;
        for (int k = 0; k < 40 && s < 4; k++) begin
            @(negedge clk);
            in_valid = 1'b0;
            if (en_out) s++;
        end
        check("rst_mid_reach_4th", 32'(s), 32'd4);
        check("rst_mid_pre", {29'd0, en_out, x_out, busy}, 32'h7);
        rst = 1'b1;
        #1;
        check("rst_mid_async", {27'd0, outs()}, 32'h10);
        @(negedge clk);
        check("rst_mid_hold", {27'd0, outs()}, 32'h10);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("rst_post_idle%0d", k), {27'd0, outs()}, 32'h10);
        end
        plan.delete();
        plan.push_back('{8'h55, 0, 1'b0, 1});
        build_plan();
        run_plan("post");
        check("post_rst_strobes", 32'(obs.size()), 32'd8);
        if (obs.size() == 8) begin
            for (int j = 0; j < 8; j++) pk[7-j] = obs[j];
            check("post_rst_bits", 32'(pk), 32'h55);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
